// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between two requesters and the shared ALU arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface alu_share_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [XLEN-1:0] req_a0;
    logic [XLEN-1:0] req_b0;
    logic [XLEN-1:0] req_a1;
    logic [XLEN-1:0] req_b1;
    logic [3:0]      req_ctrl0;
    logic [3:0]      req_ctrl1;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_zero;
    logic            rsp_err;
    logic            busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_ctrl0, req_ctrl1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_ctrl0, req_ctrl1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU: IDLE grants, EXEC computes,
// RESP holds the registered result until the owning requester accepts it.
module alu_share_arbiter #(
    parameter int   XLEN    = 32,
    parameter logic RR_INIT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            last_grant_r;
    logic            owner_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [3:0]      ctrl_r;
    logic [XLEN-1:0] data_r;
    logic            zero_r;
    logic            err_r;

    logic            grant_vld_s;
    logic            grant_id_s;
    logic            rsp_hs_s;
    logic [XLEN:0]   alu_s;
    logic [1:0]      req_ready_s;
    logic [1:0]      rsp_valid_s;
    logic            busy_s;

    // Returns {err, result}; unsupported codes give a zero result with err set.
    function automatic logic [XLEN:0] alu_f(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [3:0]      op
    );
        logic [XLEN-1:0] r;
        logic            e;
        logic [SHW-1:0]  sh;
        sh = b[SHW-1:0];
        r  = {XLEN{1'b0}};
        e  = 1'b0;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a << sh;
            4'b0101: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0110: r = a ^ b;
            4'b0111: r = a >> sh;
            4'b1000: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b1001: r = $unsigned($signed(a) >>> sh);
            default: begin
                r = {XLEN{1'b0}};
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    assign alu_s = alu_f(a_r, b_r, ctrl_r);

    // Round-robin pick among requesters; only offered in IDLE and out of reset.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        if (reset && (state_r == ST_IDLE)) begin
            case (bus.req_valid)
                2'b01: begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = 1'b0;
                end
                2'b10: begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = 1'b1;
                end
                2'b11: begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = ~last_grant_r;
                end
                default: begin
                    grant_vld_s = 1'b0;
                    grant_id_s  = 1'b0;
                end
            endcase
        end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    // Response handshake only counts the owner's rsp_ready.
    always_comb begin
        rsp_hs_s = 1'b0;
        if (state_r == ST_RESP) begin
            rsp_hs_s = bus.rsp_ready[owner_r];
        end else begin
            rsp_hs_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready follows the live arbitration.
    always_comb begin
        req_ready_s = 2'b00;
        rsp_valid_s = 2'b00;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    req_ready_s = grant_id_s ? 2'b10 : 2'b01;
                end else begin
                    req_ready_s = 2'b00;
                end
            end
            ST_EXEC: busy_s = 1'b1;
            ST_RESP: begin
                busy_s      = 1'b1;
                rsp_valid_s = owner_r ? 2'b10 : 2'b01;
            end
            default: begin
                req_ready_s = 2'b00;
                rsp_valid_s = 2'b00;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Operand capture on grant, result capture in EXEC, pointer update on response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= RR_INIT;
            owner_r      <= 1'b0;
            a_r          <= {XLEN{1'b0}};
            b_r          <= {XLEN{1'b0}};
            ctrl_r       <= 4'b0000;
            data_r       <= {XLEN{1'b0}};
            zero_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            if (grant_vld_s) begin
                owner_r <= grant_id_s;
                a_r     <= grant_id_s ? bus.req_a1    : bus.req_a0;
                b_r     <= grant_id_s ? bus.req_b1    : bus.req_b0;
                ctrl_r  <= grant_id_s ? bus.req_ctrl1 : bus.req_ctrl0;
            end
            if (state_r == ST_EXEC) begin
                data_r <= alu_s[XLEN-1:0];
                zero_r <= (alu_s[XLEN-1:0] == {XLEN{1'b0}});
                err_r  <= alu_s[XLEN];
            end
            if (rsp_hs_s) begin
                last_grant_r <= owner_r;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_data  = data_r;
    assign bus.rsp_zero  = zero_r;
    assign bus.rsp_err   = err_r;
    assign bus.busy      = busy_s;

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter RR_INIT, default 1'b1, initial last-grant pointer, so requester 0 wins the first tie.
REQ-003 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-low; state clears while low.
REQ-005 SHALL have ports: req_valid  input  2  per-requester request strobe; bit i = requester i.
REQ-006 SHALL have ports: req_ready  output  2  per-requester accept; at most one bit high.
REQ-007 SHALL have ports: req_a0, req_b0, req_a1, req_b1  input  XLEN  operands per requester.
REQ-008 SHALL have ports: req_ctrl0, req_ctrl1  input  4  ALUControl code per requester.
REQ-009 SHALL have ports: rsp_valid  output  2  result valid to owning requester.
REQ-010 SHALL have ports: rsp_ready  input  2  per-requester result accept.
REQ-011 SHALL have ports: rsp_data  output  XLEN  registered result, shared bus.
REQ-012 SHALL have ports: rsp_zero  output  1  high when rsp_data == 0.
REQ-013 SHALL have ports: rsp_err  output  1  high when the executed code was unsupported.
REQ-014 SHALL have ports: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE with any req_valid, SHALL grant one requester; req_ready for that requester is combinational, asserted only in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both request, grant the requester not equal to last_grant; if one requests, grant it.
REQ-018 On the handshake (req_valid[i] & req_ready[i]), SHALL latch operands, ctrl and owner id i, and go to EXEC.
REQ-019 In EXEC (one cycle), SHALL compute the result from latched operands, register rsp_data/rsp_zero/rsp_err, and go to RESP.
REQ-020 Op encoding SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt signed, 0110 xor, 0111 srl, 1000 sltu, 1001 sra.
REQ-021 Shifts SHALL use b[4:0] (log2 XLEN bits); add/sub wrap modulo 2^XLEN; slt/sltu yield 1 or 0 zero-extended.
REQ-022 Codes 1010-1111 SHALL yield rsp_data 0, rsp_zero 1, rsp_err 1; the transaction completes normally.
REQ-023 In RESP, SHALL assert rsp_valid[owner] only; rsp_data/zero/err held stable until rsp_ready[owner].
REQ-024 On rsp_valid[owner] & rsp_ready[owner], SHALL update last_grant to owner and go to IDLE; new grant is earliest next cycle.
REQ-025 rsp_ready of the non-owner SHALL be ignored; req_valid during EXEC/RESP SHALL be ignored (req_ready low).
REQ-026 Accept-to-rsp_valid latency SHALL be 2 cycles; minimum issue interval 3 cycles.
REQ-027 Requester deasserting req_valid before grant SHALL lose nothing; no request is latched without the handshake.

Reset
REQ-028 While reset low: state IDLE, last_grant=RR_INIT, req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, busy=0.
REQ-029 Reset asserted mid-EXEC or mid-RESP SHALL abort the transaction; no rsp_valid after release.
REQ-030 First grant SHALL be possible in the first clock edge after reset deasserts.

Verification
REQ-031 Single req0 add a=5,b=7 -> req_ready[0] cycle 0, rsp_valid[0] cycle 2, rsp_data=12, rsp_zero=0.
REQ-032 Both valid continuously after reset, ctrl sub 3-3 and xor F0^0F -> grants 0,1,0,1; rsp 0 (zero=1), rsp FF alternately.
REQ-033 req1 sra a=0x80000000,b=4 -> 0xF8000000; srl same -> 0x08000000; slt -1<1 -> 1; sltu -> 0.
REQ-034 rsp_ready[owner] held low 5 cycles -> rsp_valid/rsp_data stable, busy=1, req_ready=00 throughout.
REQ-035 ctrl=1111 -> rsp_data=0, rsp_zero=1, rsp_err=1, FSM returns IDLE.
REQ-036 reset low during RESP -> all outputs zero immediately; after release no stale rsp_valid; req0 wins first tie.
